// File: rtl/serial_addsub_ctrl.sv
// Bit-serial N-bit adder/subtractor: one full-adder slice is sequenced LSB-first
// over N cycles, with a carry flip-flop linking the bit steps.
module serial_addsub_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         M,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  r_sr;
    logic [CW-1:0] cnt;
    logic          m;
    logic          c;

    logic          bx;
    logic          d;
    logic          c_next;
    logic          c_msb_in;
    logic          last_bit;
    logic [N-1:0]  r_full;

    // Single 1-bit slice: returns {carry_out, sum}.
    function automatic logic [1:0] fa_step(input logic a, input logic b, input logic cin);
        logic sum;
        logic carry;
        sum   = a ^ b ^ cin;
        carry = (a & b) | ((a ^ b) & cin);
        return {carry, sum};
    endfunction

    always_comb begin
        bx       = b_sr[0] ^ m;
        {c_next, d} = fa_step(a_sr[0], bx, c);
        last_bit = (cnt == CW'(N - 1));
        // On the final step c is the carry into the MSB, needed for overflow.
        c_msb_in = c;
        r_full   = {d, r_sr[N-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            cnt  <= '0;
            m    <= 1'b0;
            c    <= 1'b0;
            S    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        m    <= M;
                        // Seeding carry with the mode bit supplies the +1 of A + ~B + 1.
                        c    <= M;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_full;
                    c    <= c_next;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        S    <= r_full;
                        cout <= c_next;
                        ovf  <= c_msb_in ^ c_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed testbench for serial_addsub_ctrl with N=8.
module tb_serial_addsub_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         M;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         cout;
    logic         ovf;

    int errors;
    int checks;
    int cyc_cnt;

    serial_addsub_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .M     (M),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Accepts one operation at the next edge and waits (bounded) for done.
    // cyc = negedges from accept until done seen (0 if never); proto_bad flags
    // busy low before done or busy/done overlap.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic mode,
                          output int cyc, output bit proto_bad);
        cyc       = 0;
        proto_bad = 1'b0;
        A = a; B = b; M = mode; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (busy && done) proto_bad = 1'b1;
            if (done) begin
                cyc = i;
                break;
            end
            if (!busy) proto_bad = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit busy_seen;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; M = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, done, S, cout, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b S=%h cout=%b ovf=%b, want all 0",
                     busy, done, S, cout, ovf);
        end
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) busy_seen = 1'b1;
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy/done went high with start=0, want stay 0");
        end
    endtask

    task automatic test_arith(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic mode, input logic [N-1:0] exp_s,
                              input logic exp_c, input logic exp_v);
        int cyc;
        bit bad;
        run_op(a, b, mode, cyc, bad);
        checks++;
        if (cyc !== N + 1) begin
            errors++;
            $display("FAIL %s_latency: done at negedge %0d after accept, want %0d", name, cyc, N + 1);
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: busy not continuous or overlapped done, want clean busy then done", name);
        end
        checks++;
        if ({S, cout, ovf} !== {exp_s, exp_c, exp_v}) begin
            errors++;
            $display("FAIL %s_result: got S=%h cout=%b ovf=%b, want S=%h cout=%b ovf=%b",
                     name, S, cout, ovf, exp_s, exp_c, exp_v);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_width: done=%b one cycle later, want 0", name, done);
        end
    endtask

    task automatic test_start_ignored();
        bit got_done;
        A = 8'h05; B = 8'h03; M = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'h10; B = 8'h20; M = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got_done || S !== 8'h08 || cout !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: got done=%b S=%h cout=%b, want done=1 S=08 cout=0",
                     got_done, S, cout);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_no_rerun: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_hold_start();
        int stamps[3];
        int n;
        n = 0;
        A = 8'h01; B = 8'h02; M = 1'b0; start = 1'b1;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (done) begin
                stamps[n] = cyc_cnt;
                n++;
            end
        end
        start = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL hold_start_count: got %0d done pulses, want 3", n);
        end else begin
            checks++;
            if ((stamps[1] - stamps[0]) !== N + 2 || (stamps[2] - stamps[1]) !== N + 2) begin
                errors++;
                $display("FAIL hold_start_period: got %0d,%0d cycles, want %0d",
                         stamps[1] - stamps[0], stamps[2] - stamps[1], N + 2);
            end
        end
        checks++;
        if (S !== 8'h03) begin
            errors++;
            $display("FAIL hold_start_result: got S=%h, want 03", S);
        end
        repeat (N + 3) @(negedge clk);
    endtask

    task automatic test_input_change();
        bit got_done;
        bit s_moved;
        logic [N-1:0] prev_s;
        prev_s = S;
        A = 8'h12; B = 8'h34; M = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        got_done = 1'b0;
        s_moved  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (S !== prev_s) s_moved = 1'b1;
            A = A ^ 8'hA5; B = B + 8'h3C; M = ~M;
            @(negedge clk);
        end
        checks++;
        if (s_moved !== 1'b0) begin
            errors++;
            $display("FAIL input_change_hold: S changed during RUN, want held at %h", prev_s);
        end
        checks++;
        if (!got_done || {S, cout, ovf} !== {8'h46, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL input_change_result: got done=%b S=%h cout=%b ovf=%b, want 1 46 0 0",
                     got_done, S, cout, ovf);
        end
        M = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit done_seen;
        A = 8'h55; B = 8'h11; M = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, done, S, cout, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b S=%h cout=%b ovf=%b, want all 0",
                     busy, done, S, cout, ovf);
        end
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: aborted op still showed busy/done, want none");
        end
        test_arith("after_reset", 8'h0A, 8'h04, 1'b0, 8'h0E, 1'b0, 1'b0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        cyc_cnt = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        A = '0; B = '0; M = 1'b0;
        @(negedge clk);
        test_reset();
        test_arith("add_5_3",   8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        test_arith("add_ff_1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        test_arith("sub_5_3",   8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);
        test_arith("sub_3_5",   8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
        test_arith("ovf_add",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        test_arith("ovf_sub",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        test_start_ignored();
        test_hold_start();
        test_input_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial N-bit adder/subtractor controller. It accepts two N-bit operands and a mode bit, then sequences a single 1-bit full adder/subtractor slice LSB-first over N cycles. A carry flip-flop links the bit steps. At the end it presents the N-bit result, carry/borrow-out and signed overflow. It lets wide add/subtract share one 1-bit slice, trading latency for area in the lab datapath.

## Interface
- `N`, default 8: operand/result width; legal range N ≥ 2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `start` input, 1 bit: request; sampled only in IDLE.
- `M` input, 1 bit: mode; 0 = add A+B, 1 = subtract A−B. Latched with `start`.
- `A` input, N bits: operand A; latched with `start`.
- `B` input, N bits: operand B; latched with `start`.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: one-cycle completion pulse.
- `S` output, N bits: result, registered and held between operations.
- `cout` output, 1 bit: final carry; in subtract mode, 1 = no borrow.
- `ovf` output, 1 bit: two's-complement overflow.

## Operation
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `busy`, `done`, `S`, `cout`, `ovf`, the carry flip-flop, the bit counter and the operand shift registers all go to 0.
  - Reset takes priority over every other input.
- States: IDLE, RUN, DONE.
- IDLE with `start`=1:
  - Load `A` into shift register `a_sr` and `B` into shift register `b_sr`.
  - Latch `M`; set carry `c` to `M`; set the counter to 0.
  - Go to RUN.
- IDLE with `start`=0: stay in IDLE.
- RUN, one bit per cycle:
  - `bx = b_sr[0] ^ M`.
  - `d = a_sr[0] ^ bx ^ c`.
  - `c_next = (a_sr[0] & bx) | ((a_sr[0] ^ bx) & c)`.
  - Shift `a_sr` and `b_sr` right by one, and shift `d` into the MSB of the internal result register `r_sr`.
  - `c` takes `c_next`; the counter increments.
  - On the Nth bit step (counter = N−1): save the carry into bit N−1 as `c_msb_in`, then go to DONE.
- Output register update, on the same edge as the N−1 → DONE transition:
  - `S` gets the complete result (`r_sr` including the final bit).
  - `cout` gets `c_next`.
  - `ovf` gets `c_msb_in ^ c_next`.
- DONE: `done`=1 for exactly one cycle, then unconditionally back to IDLE.
  - `start` is ignored in DONE and in RUN; held operands are not disturbed.
- `S`, `cout` and `ovf` are stable at all times except the single update edge. They keep the previous result throughout a new RUN.
- Arithmetic is modulo 2^N.
  - Subtraction is A + ~B + 1, done by inverting B per bit and seeding carry-in with `M`.
- Counter width is ceil(log2(N)). Wrap-around never occurs, because the counter is cleared at each accept.
- Input changes on `A`, `B` or `M` after the accept edge have no effect on the running operation.

## Timing
- `start` sampled at edge k:
  - `busy`=1 from edge k through edge k+N−1; `busy` drops at edge k+N.
  - `done`=1 between edges k+N and k+N+1.
  - `S`, `cout` and `ovf` are valid from edge k+N.
- Latency from start to done: N cycles. Minimum start-to-start period: N+2 cycles.
- `start` held high continuously: a new operation is accepted at every IDLE cycle, i.e. every N+2 cycles.
- `rst_n` low during RUN or DONE:
  - The operation aborts; `done` is not pulsed for it.
  - Outputs are 0 from the next edge.
- `busy` and `done` are never high together.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles, then 1 with `start`=0 → all outputs 0; `busy` stays 0 indefinitely.
- Add, N=8:
  - A=0x05, B=0x03, M=0, start pulse → `busy` for 8 cycles, then `done` → S=0x08, `cout`=0, `ovf`=0.
  - A=0xFF, B=0x01, M=0 → S=0x00, `cout`=1, `ovf`=0.
- Subtract, N=8:
  - A=0x05, B=0x03, M=1 → S=0x02, `cout`=1.
  - A=0x03, B=0x05, M=1 → S=0xFE, `cout`=0, `ovf`=0.
- Overflow, N=8:
  - A=0x7F, B=0x01, M=0 → S=0x80, `ovf`=1.
  - A=0x80, B=0x01, M=1 → S=0x7F, `ovf`=1, `cout`=1.
- Protocol:
  - Pulse `start` mid-RUN with different operands → ignored; result is from the first operands.
  - Hold `start`=1 continuously → `done` pulses every 10 cycles.
  - Change A/B/M during RUN → no effect on the result.
- Reset mid-operation: assert `rst_n`=0 at RUN bit 3 for one edge → next cycle is IDLE with all outputs 0 and no `done`. A following start with A=0x0A, B=0x04, M=0 gives S=0x0E.
